// File: rtl/uart_tx_port_if.sv
// Data-port store bus seen by the UART transmit port.
// Handshake: a store is offered when wren is high at a rising clock edge and
// the port accepts it at that same edge unless write_busy was high before the
// edge; there is no stall, so a store offered while busy is dropped.
interface uart_tx_port_if #(
    parameter int ADDR_W = 15
);
    logic              wren;
    logic [ADDR_W-1:0] Daddr;
    logic [31:0]       datain;
    logic              write_busy;

    modport master (
        output wren,
        output Daddr,
        output datain,
        input  write_busy
    );

    modport slave (
        input  wren,
        input  Daddr,
        input  datain,
        output write_busy
    );
endinterface

// File: rtl/uart_tx_port.sv
// UART transmit port: captures CPU stores to PORT_ADDR into a small FIFO and
// serialises each byte as 8N1 (start, 8 data bits LSB first, stop) on txd.
module uart_tx_port #(
    parameter int                ADDR_W    = 15,
    parameter logic [ADDR_W-1:0] PORT_ADDR = 15'h7FF0,
    parameter int                CLK_DIV   = 434,
    parameter int                FIFO_AW   = 2
) (
    input  logic               clock,
    input  logic               sync_reset_n,
    uart_tx_port_if.slave      bus,
    output logic               txd,
    output logic               tx_active,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overflow,
    output logic [1:0]         state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int               DEPTH_I  = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH    = DEPTH_I[FIFO_AW:0];
    localparam logic [15:0]      DIV_LAST = 16'(CLK_DIV - 1);

    state_t               state_q, state_d;
    logic [15:0]          div_q, div_d;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           shift_q, shift_d;
    logic                 txd_q, txd_d;
    logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]     count_q, count_d;
    logic                 busy_q;
    logic                 overflow_q;
    logic [7:0]           mem_q [DEPTH_I];

    logic                 addr_hit;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 div_last;
    logic                 unused_hi;

    // Only the low byte of a store is transmitted; upper lanes are ignored.
    assign unused_hi = ^bus.datain[31:8];

    assign addr_hit = bus.wren && (bus.Daddr == PORT_ADDR);
    assign full     = (count_q == DEPTH);
    // Fullness is judged before the edge, so a same-cycle pop never frees room.
    assign push     = addr_hit && !full;
    assign div_last = (div_q == DIV_LAST);

    // Next-state, divider, bit index, shifter and line level.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    div_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (div_last) begin
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            DATA: begin
                if (div_last) begin
                    div_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            STOP: begin
                if (div_last) begin
                    div_d = '0;
                    // Chain straight into the next frame when data is waiting.
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the state being entered so txd is glitch-free.
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    // FIFO occupancy after this cycle's push and pop.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + {{FIFO_AW{1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{FIFO_AW{1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Control registers: FSM, counters, FIFO pointers and status flags.
    always_ff @(posedge clock) begin
        if (!sync_reset_n) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            count_q  <= count_d;
            busy_q   <= (count_d == DEPTH);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + {{(FIFO_AW-1){1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + {{(FIFO_AW-1){1'b0}}, 1'b1};
            end
            if (addr_hit && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset since the pointers gate them.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.datain[7:0];
        end
    end

    assign txd            = txd_q;
    assign tx_active      = (state_q != IDLE);
    assign fifo_count     = count_q;
    assign overflow       = overflow_q;
    assign bus.write_busy = busy_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed bench for uart_tx_port with CLK_DIV=4 and a 4-entry FIFO.
module tb_uart_tx_port;

    localparam int          DIV = 4;
    localparam logic [14:0] PA  = 15'h7FF0;

    logic       clock = 1'b0;
    logic       sync_reset_n;
    logic       txd;
    logic       tx_active;
    logic [2:0] fifo_count;
    logic       overflow;
    logic [1:0] state_o;

    int checks = 0;
    int passes = 0;

    logic       cap_en = 1'b0;
    logic       cap_q[$];
    int         act_cnt = 0;
    logic [7:0] exp_q[$];

    uart_tx_port_if #(.ADDR_W(15)) bus ();

    uart_tx_port #(
        .ADDR_W   (15),
        .PORT_ADDR(PA),
        .CLK_DIV  (DIV),
        .FIFO_AW  (2)
    ) dut (
        .clock       (clock),
        .sync_reset_n(sync_reset_n),
        .bus         (bus),
        .txd         (txd),
        .tx_active   (tx_active),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .state_o     (state_o)
    );

    // Clock / reset
    always #5 clock = ~clock;

    // Driver tasks
    task automatic step();
        @(negedge clock);
        if (cap_en) begin
            cap_q.push_back(txd);
            if (tx_active) act_cnt++;
        end
    endtask

    task automatic drive_write(input logic [14:0] addr, input logic [31:0] data);
        bus.wren   = 1'b1;
        bus.Daddr  = addr;
        bus.datain = data;
    endtask

    task automatic bus_idle();
        bus.wren   = 1'b0;
        bus.Daddr  = '0;
        bus.datain = '0;
    endtask

    task automatic apply_reset();
        cap_en = 1'b0;
        bus_idle();
        sync_reset_n = 1'b0;
        step();
        sync_reset_n = 1'b1;
        step();
    endtask

    // Expected 8N1 waveform of one byte, one entry per clock.
    function automatic logic [39:0] frame_of(input logic [7:0] b);
        logic [39:0] f;
        for (int k = 0; k < 40; k++) begin
            if (k < DIV)            f[k] = 1'b0;
            else if (k < 9 * DIV)   f[k] = b[(k - DIV) / DIV];
            else                    f[k] = 1'b1;
        end
        return f;
    endfunction

    // 40 captured txd samples starting at base, X when past the capture.
    function automatic logic [39:0] slice40(input int base);
        logic [39:0] s;
        for (int k = 0; k < 40; k++) begin
            if (base + k < cap_q.size()) s[k] = cap_q[base + k];
            else                         s[k] = 1'bx;
        end
        return s;
    endfunction

    task automatic test_reset();
        bus_idle();
        sync_reset_n = 1'b0;
        step();
        step();
        checks++; if (txd !== 1'b1) $display("FAIL reset_txd got %b want 1", txd); else passes++;
        checks++; if (tx_active !== 1'b0) $display("FAIL reset_tx_active got %b want 0", tx_active); else passes++;
        checks++; if (fifo_count !== 3'd0) $display("FAIL reset_fifo_count got %0d want 0", fifo_count); else passes++;
        checks++; if (bus.write_busy !== 1'b0) $display("FAIL reset_write_busy got %b want 0", bus.write_busy); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else passes++;
        checks++; if (state_o !== 2'd0) $display("FAIL reset_state got %0d want 0", state_o); else passes++;
        sync_reset_n = 1'b1;
        step();
    endtask

    task automatic test_single_frame();
        cap_q.delete();
        exp_q.delete();
        act_cnt = 0;
        drive_write(PA, 32'h0000_00A5);
        cap_en = 1'b1;
        step();
        bus_idle();
        checks++; if (fifo_count !== 3'd1) $display("FAIL single_count_after_push got %0d want 1", fifo_count); else passes++;
        checks++; if (txd !== 1'b1) $display("FAIL single_txd_before_start got %b want 1", txd); else passes++;
        repeat (40) step();
        step();
        cap_en = 1'b0;
        checks++; if (act_cnt !== 40) $display("FAIL single_tx_active_len got %0d want 40", act_cnt); else passes++;
        checks++; if (cap_q.size() != 42) $display("FAIL single_len got %0d want 42", cap_q.size()); else passes++;
        checks++; if (cap_q[41] !== 1'b1 || tx_active !== 1'b0) $display("FAIL single_idle_after got txd=%b act=%b want 1/0", cap_q[41], tx_active); else passes++;
        exp_q.push_back(8'hA5);
        for (int f = 0; exp_q.size() > 0; f++) begin
            logic [7:0] b;
            b = exp_q.pop_front();
            checks++;
            if (slice40(1 + 40 * f) !== frame_of(b))
                $display("FAIL single_frame%0d got %h want %h", f, slice40(1 + 40 * f), frame_of(b));
            else passes++;
        end
    endtask

    task automatic test_addr_decode();
        drive_write(PA - 15'd4, 32'h0000_0055);
        step();
        checks++; if (fifo_count !== 3'd0) $display("FAIL decode_below got %0d want 0", fifo_count); else passes++;
        drive_write(PA + 15'd1, 32'h0000_0055);
        step();
        bus_idle();
        checks++; if (fifo_count !== 3'd0) $display("FAIL decode_above got %0d want 0", fifo_count); else passes++;
        step();
        step();
        checks++; if (txd !== 1'b1 || tx_active !== 1'b0) $display("FAIL decode_line got txd=%b act=%b want 1/0", txd, tx_active); else passes++;
    endtask

    task automatic test_back_to_back();
        cap_q.delete();
        exp_q.delete();
        cap_en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            drive_write(PA, 32'(i));
            step();
        end
        checks++; if (fifo_count !== 3'd4) $display("FAIL b2b_count_full got %0d want 4", fifo_count); else passes++;
        checks++; if (bus.write_busy !== 1'b1) $display("FAIL b2b_busy_set got %b want 1", bus.write_busy); else passes++;
        drive_write(PA, 32'h0000_00FF);
        step();
        bus_idle();
        checks++; if (overflow !== 1'b1) $display("FAIL ovf_set got %b want 1", overflow); else passes++;
        checks++; if (fifo_count !== 3'd4) $display("FAIL ovf_count got %0d want 4", fifo_count); else passes++;
        repeat (35) step();
        checks++; if (bus.write_busy !== 1'b1) $display("FAIL b2b_busy_hold got %b want 1", bus.write_busy); else passes++;
        step();
        checks++; if (bus.write_busy !== 1'b0) $display("FAIL b2b_busy_clear got %b want 0", bus.write_busy); else passes++;
        checks++; if (fifo_count !== 3'd3) $display("FAIL b2b_count_after_pop got %0d want 3", fifo_count); else passes++;
        repeat (160) step();
        cap_en = 1'b0;
        checks++; if (cap_q.size() != 202) $display("FAIL b2b_len got %0d want 202", cap_q.size()); else passes++;
        checks++; if (cap_q[201] !== 1'b1 || tx_active !== 1'b0) $display("FAIL b2b_idle_after got txd=%b act=%b want 1/0", cap_q[201], tx_active); else passes++;
        for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
        for (int f = 0; exp_q.size() > 0; f++) begin
            logic [7:0] b;
            b = exp_q.pop_front();
            checks++;
            if (slice40(1 + 40 * f) !== frame_of(b))
                $display("FAIL b2b_frame%0d got %h want %h", f, slice40(1 + 40 * f), frame_of(b));
            else passes++;
        end
        checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b want 1", overflow); else passes++;
    endtask

    task automatic test_push_pop_same_cycle();
        apply_reset();
        checks++; if (overflow !== 1'b0) $display("FAIL ovf_cleared_by_reset got %b want 0", overflow); else passes++;
        cap_q.delete();
        exp_q.delete();
        cap_en = 1'b1;
        drive_write(PA, 32'h0000_0010);
        step();
        drive_write(PA, 32'h0000_0020);
        step();
        drive_write(PA, 32'h0000_0030);
        step();
        bus_idle();
        checks++; if (fifo_count !== 3'd2) $display("FAIL pp_count_before got %0d want 2", fifo_count); else passes++;
        repeat (38) step();
        drive_write(PA, 32'h1234_5640);
        step();
        bus_idle();
        checks++; if (fifo_count !== 3'd2) $display("FAIL pp_count_same got %0d want 2", fifo_count); else passes++;
        repeat (120) step();
        cap_en = 1'b0;
        checks++; if (cap_q.size() != 162) $display("FAIL pp_len got %0d want 162", cap_q.size()); else passes++;
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h40);
        for (int f = 0; exp_q.size() > 0; f++) begin
            logic [7:0] b;
            b = exp_q.pop_front();
            checks++;
            if (slice40(1 + 40 * f) !== frame_of(b))
                $display("FAIL pp_frame%0d got %h want %h", f, slice40(1 + 40 * f), frame_of(b));
            else passes++;
        end
    endtask

    task automatic test_reset_mid_frame();
        cap_en = 1'b0;
        drive_write(PA, 32'h0000_003C);
        step();
        drive_write(PA, 32'h0000_0077);
        step();
        bus_idle();
        repeat (17) step();
        checks++; if (state_o !== 2'd2 || txd !== 1'b1) $display("FAIL mid_bit3 got state=%0d txd=%b want 2/1", state_o, txd); else passes++;
        checks++; if (fifo_count !== 3'd1) $display("FAIL mid_count got %0d want 1", fifo_count); else passes++;
        sync_reset_n = 1'b0;
        step();
        checks++; if (txd !== 1'b1 || tx_active !== 1'b0) $display("FAIL mid_reset_line got txd=%b act=%b want 1/0", txd, tx_active); else passes++;
        checks++; if (fifo_count !== 3'd0 || overflow !== 1'b0) $display("FAIL mid_reset_fifo got cnt=%0d ovf=%b want 0/0", fifo_count, overflow); else passes++;
        sync_reset_n = 1'b1;
        step();
        cap_q.delete();
        exp_q.delete();
        drive_write(PA, 32'h0000_00C3);
        cap_en = 1'b1;
        step();
        bus_idle();
        repeat (41) step();
        cap_en = 1'b0;
        checks++; if (cap_q.size() != 42 || cap_q[41] !== 1'b1) $display("FAIL mid_after_len got %0d want 42", cap_q.size()); else passes++;
        exp_q.push_back(8'hC3);
        for (int f = 0; exp_q.size() > 0; f++) begin
            logic [7:0] b;
            b = exp_q.pop_front();
            checks++;
            if (slice40(1 + 40 * f) !== frame_of(b))
                $display("FAIL mid_after_frame%0d got %h want %h", f, slice40(1 + 40 * f), frame_of(b));
            else passes++;
        end
    endtask

    // Test sequence and final report
    initial begin
        bus_idle();
        sync_reset_n = 1'b0;
        test_reset();
        test_single_frame();
        test_addr_decode();
        test_back_to_back();
        test_push_pop_same_cycle();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_port.md
Name: uart_tx_port

Overview:
- Downstream consumer of CPU data-port stores to the UART port address. Captures the byte written, buffers it in a small FIFO, and serialises it as 8N1 on txd.
- Drives write_busy back to the data-memory read mux, so software polling the UART port sees bit 8 set while the FIFO is full.
- Sits beside the data RAM on the same Daddr/datain/wren bus, on the single core clock.

Parameters:
- PORT_ADDR, 15'h7FF0: Daddr value that selects the UART transmit port.
- ADDR_W, 15: width of Daddr.
- CLK_DIV, 434: core clocks per bit period (115200 baud at 50 MHz); legal range 2..65535.
- FIFO_AW, 2: FIFO address bits; depth = 2**FIFO_AW = 4.

Ports:
- clock  in  1  core clock; all state changes on its rising edge.
- sync_reset_n  in  1  synchronous, active-low reset.
- wren  in  1  data-port write strobe.
- Daddr  in  ADDR_W  data-port byte address.
- datain  in  32  store data; only datain[7:0] is used.
- txd  out  1  serial output, idle high.
- write_busy  out  1  high when the FIFO is full.
- tx_active  out  1  high while a frame is on the line (START, DATA or STOP).
- fifo_count  out  FIFO_AW+1  number of bytes queued, excluding the byte in the shifter.
- overflow  out  1  sticky flag: a write was dropped because the FIFO was full.

Behaviour:
- Reset (sync_reset_n low at an edge):
  - txd=1, write_busy=0, tx_active=0, fifo_count=0, overflow=0.
  - FSM goes to IDLE, divider and bit counters go to 0.
  - FIFO pointers clear; queued data is discarded.
  - Reset mid-frame aborts the frame; txd returns to 1 on the next cycle.
- Push:
  - A push is accepted at an edge when wren=1, Daddr==PORT_ADDR and fifo_count<depth, all evaluated before the edge.
  - access_mode is ignored; byte, word and long stores all push datain[7:0].
  - A write while full is dropped and sets overflow=1. overflow is cleared only by reset.
  - A pop in the same cycle does not make room for a push in that cycle.
- write_busy = (fifo_count==depth). It is registered and updates the cycle after a push or pop.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If fifo_count>0, pop the FIFO head into the shift register, clear the divider, go to START.
  - START: txd=0 for CLK_DIV clocks, then go to DATA with bit index 0.
  - DATA: txd=shift[0] for CLK_DIV clocks, then shift right. After bit index 7, go to STOP.
  - STOP: txd=1 for CLK_DIV clocks. On the terminal divider count:
    - if fifo_count>0, pop and go directly to START (no idle cycle between frames);
    - otherwise go to IDLE.
- Divider: counts 0..CLK_DIV-1 and wraps. The state or bit advances when the count equals CLK_DIV-1.
- Frame length is exactly 10*CLK_DIV clocks; data is sent LSB first.
- Latency:
  - push accepted at edge N → fifo_count=1 after edge N;
  - FSM pops at edge N+1 → txd=0 from edge N+1.
- Simultaneous push and pop (not full): fifo_count stays unchanged and both operations take effect.
- Pointers are FIFO_AW bits and wrap modulo depth. Full/empty come from fifo_count, not from pointer compare.
- tx_active=1 in START, DATA and STOP; 0 in IDLE. txd is driven from a register, so no glitches.

Test Plan:
- CLK_DIV=4, reset, one write of 32'h0000_00A5 to PORT_ADDR → txd low 4 clocks starting 1 cycle after accept, then bits 1,0,1,0,0,1,0,1 for 4 clocks each, then high 4 clocks; tx_active high for exactly 40 clocks.
- Write 8'h55 to PORT_ADDR-4 and to PORT_ADDR+1 → no push; fifo_count stays 0; txd stays 1.
- Five back-to-back writes 8'h01..8'h05 on consecutive cycles, CLK_DIV=4:
  - first byte pops at once and four queue;
  - write_busy=1 after the fifth push and clears one cycle after the next pop;
  - five frames go out with no idle gap, in order 01..05.
- With write_busy=1, write 8'hFF → overflow=1, fifo_count stays 4, and FF is never transmitted. overflow stays 1 until reset.
- Push and pop in the same cycle with fifo_count=2 → fifo_count remains 2, and the next frame carries the oldest byte.
- Assert sync_reset_n=0 during DATA bit 3 → next cycle txd=1, tx_active=0, fifo_count=0, overflow=0. A new write afterwards transmits a complete, correct frame.
